// File: rtl/accel_model_pkg.sv
// Shared types and default parameters
// for the keyed round accelerator model.
package accel_model_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_e;

  typedef enum logic {
    OP_ENC,
    OP_DEC
  } op_e;

  localparam int DEF_DATA_W   = 128;
  localparam int DEF_LATENCY  = 64;
  localparam int DEF_NUM_KEYS = 4;

endpackage

// File: rtl/accel_model_round.sv
// One combinational round of the keyed
// rotate/xor cipher; dec inverts enc.
module accel_model_round
  import accel_model_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] key,
  input  op_e               op,
  output logic [DATA_W-1:0] nxt
);

  logic [DATA_W-1:0] rotl;
  logic [DATA_W-1:0] mix;
  logic [DATA_W-1:0] rotr;

  assign rotl = {acc[DATA_W-2:0], acc[DATA_W-1]};
  assign mix  = acc ^ key;
  assign rotr = {mix[0], mix[DATA_W-1:1]};

  always_comb begin
    nxt = rotl ^ key;
    unique case (op)
      OP_ENC:  nxt = rotl ^ key;
      OP_DEC:  nxt = rotr;
      default: nxt = rotl ^ key;
    endcase
  end

endmodule

// File: rtl/accel_model_param.sv
// Multi-cycle keyed accelerator with key
// slots, abort and error reporting.
module accel_model_param
  import accel_model_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LATENCY  = DEF_LATENCY,
  parameter int NUM_KEYS = DEF_NUM_KEYS,
  localparam int KS_W =
    (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
  localparam int CNT_W = $clog2(LATENCY + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_key_i,
  input  logic [KS_W-1:0]   key_sel_i,
  input  logic              start_enc_i,
  input  logic              start_dec_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              ready_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              rf_en_o,
  output logic              err_o
);

  state_e              st_q, st_d;
  op_e                 op_q, op_d;
  logic [KS_W-1:0]     slot_q, slot_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [NUM_KEYS-1:0] vld_q, vld_d;

  logic [DATA_W-1:0]   keys_q [NUM_KEYS];
  logic [NUM_KEYS-1:0] sel_oh;
  logic                sel_vld;
  logic [DATA_W-1:0]   key_cur;
  logic [DATA_W-1:0]   rnd_nxt;
  logic                start_any;
  logic                start_both;

  assign start_any  = start_enc_i | start_dec_i;
  assign start_both = start_enc_i & start_dec_i;

  // Out-of-range selects decode to no slot,
  // so they read as invalid.
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (key_sel_i == KS_W'(i)) sel_oh[i] = 1'b1;
    end
  end

  assign sel_vld = |(sel_oh & vld_q);

  always_comb begin
    key_cur = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (slot_q == KS_W'(i)) key_cur = keys_q[i];
    end
  end

  accel_model_round #(
    .DATA_W (DATA_W)
  ) u_round (
    .acc (acc_q),
    .key (key_cur),
    .op  (op_q),
    .nxt (rnd_nxt)
  );

  always_ff @(posedge clk) begin
    if (st_q == ST_IDLE && load_key_i) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (sel_oh[i]) keys_q[i] <= data_i;
      end
    end
  end

  always_comb begin
    st_d   = st_q;
    op_d   = op_q;
    slot_d = slot_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    out_d  = out_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    vld_d  = vld_q;
    unique case (st_q)
      ST_IDLE: begin
        if (load_key_i) begin
          vld_d = vld_q | sel_oh;
        end else if (start_both) begin
          err_d = 1'b1;
        end else if (start_any) begin
          if (!sel_vld) begin
            err_d = 1'b1;
          end else begin
            acc_d  = data_i;
            op_d   = start_dec_i ? OP_DEC : OP_ENC;
            slot_d = key_sel_i;
            cnt_d  = CNT_W'(LATENCY);
            st_d   = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        err_d = load_key_i | start_any;
        if (abort_i) begin
          cnt_d = '0;
          st_d  = ST_IDLE;
        end else begin
          acc_d = rnd_nxt;
          if (cnt_q == CNT_W'(1)) begin
            out_d  = rnd_nxt;
            done_d = 1'b1;
            cnt_d  = '0;
            st_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      op_q   <= OP_ENC;
      slot_q <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      vld_q  <= '0;
    end else begin
      st_q   <= st_d;
      op_q   <= op_d;
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      out_q  <= out_d;
      done_q <= done_d;
      err_q  <= err_d;
      vld_q  <= vld_d;
    end
  end

  assign data_o  = out_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign ready_o = (st_q == ST_IDLE);
  assign busy_o  = (st_q == ST_BUSY);
  assign rf_en_o = (st_q == ST_BUSY);

endmodule

// File: tb/tb_accel_model_param.sv
// Directed bench: default instance plus a
// minimal 8-bit single-round instance.
module tb_accel_model_param;

  logic         clk = 1'b0;
  logic         rst;
  logic         load, enc, dec, abrt;
  logic [1:0]   sel;
  logic [127:0] din, dout;
  logic         rdy, done, busy, rfen, err;

  logic         s_load, s_enc, s_dec, s_abrt;
  logic [0:0]   s_sel;
  logic [7:0]   s_din, s_dout;
  logic         s_rdy, s_done, s_busy, s_rfen, s_err;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] PT =
    128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] CT =
    128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF;
  localparam logic [127:0] ONE_SH =
    128'h0000_0000_0000_0001_0000_0000_0000_0000;

  always #5 clk = ~clk;

  accel_model_param u_dut (
    .clk         (clk),
    .rst         (rst),
    .load_key_i  (load),
    .key_sel_i   (sel),
    .start_enc_i (enc),
    .start_dec_i (dec),
    .abort_i     (abrt),
    .data_i      (din),
    .data_o      (dout),
    .ready_o     (rdy),
    .done_o      (done),
    .busy_o      (busy),
    .rf_en_o     (rfen),
    .err_o       (err)
  );

  accel_model_param #(
    .DATA_W   (8),
    .LATENCY  (1),
    .NUM_KEYS (1)
  ) u_small (
    .clk         (clk),
    .rst         (rst),
    .load_key_i  (s_load),
    .key_sel_i   (s_sel),
    .start_enc_i (s_enc),
    .start_dec_i (s_dec),
    .abort_i     (s_abrt),
    .data_i      (s_din),
    .data_o      (s_dout),
    .ready_o     (s_rdy),
    .done_o      (s_done),
    .busy_o      (s_busy),
    .rf_en_o     (s_rfen),
    .err_o       (s_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [1:0] s,
                          input logic [127:0] k);
    load = 1'b1; sel = s; din = k;
    step();
    load = 1'b0;
  endtask

  task automatic start(input logic d,
                       input logic [1:0] s,
                       input logic [127:0] v);
    enc = ~d; dec = d; sel = s; din = v;
    step();
    enc = 1'b0; dec = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    total++;
    if ({rdy, done, err, busy, rfen} !== 5'b10000
        || dout !== '0) begin
      bad++;
      $display("FAIL reset: rdy/done/err/busy/rf=%b data=%h want 10000 0",
               {rdy, done, err, busy, rfen}, dout);
    end
  endtask

  task automatic test_enc_basic();
    logic early;
    load_key(2'd0, '0);
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL load_err: got %b want 0", err);
    end
    start(1'b0, 2'd0, 128'h1);
    total++;
    if ({busy, rfen, rdy} !== 3'b110) begin
      bad++;
      $display("FAIL enc_busy: busy/rf/rdy=%b want 110",
               {busy, rfen, rdy});
    end
    early = 1'b0;
    for (int i = 0; i < 63; i++) begin
      step();
      if (done !== 1'b0 || dout !== '0 || busy !== 1'b1)
        early = 1'b1;
    end
    total++;
    if (early !== 1'b0) begin
      bad++; $display("FAIL enc_during: got %b want 0", early);
    end
    step();
    total++;
    if (done !== 1'b1 || dout !== ONE_SH
        || rdy !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL enc_done: done=%b rdy=%b busy=%b data=%h want 1 1 0 %h",
               done, rdy, busy, dout, ONE_SH);
    end
    step();
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_back_to_back();
    load_key(2'd2, {16{8'hA5}});
    start(1'b0, 2'd2, PT);
    step();
    load = 1'b1; sel = 2'd2; din = '1;
    step();
    load = 1'b0;
    total++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_load_err: err=%b busy=%b want 1 1",
               err, busy);
    end
    for (int i = 0; i < 62; i++) step();
    total++;
    if (done !== 1'b1 || dout !== CT) begin
      bad++;
      $display("FAIL enc_a5: done=%b data=%h want 1 %h",
               done, dout, CT);
    end
    start(1'b1, 2'd2, CT);
    for (int i = 0; i < 64; i++) step();
    total++;
    if (done !== 1'b1 || dout !== PT) begin
      bad++;
      $display("FAIL dec_a5: done=%b data=%h want 1 %h",
               done, dout, PT);
    end
  endtask

  task automatic test_err();
    enc = 1'b1; dec = 1'b1; sel = 2'd0;
    step();
    enc = 1'b0; dec = 1'b0;
    total++;
    if ({err, rdy, busy} !== 3'b110) begin
      bad++;
      $display("FAIL both_start: err/rdy/busy=%b want 110",
               {err, rdy, busy});
    end
    step();
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL err_pulse: got %b want 0", err);
    end
    start(1'b0, 2'd3, 128'h5);
    total++;
    if ({err, rdy, busy} !== 3'b110) begin
      bad++;
      $display("FAIL inval_slot: err/rdy/busy=%b want 110",
               {err, rdy, busy});
    end
    load = 1'b1; enc = 1'b1; sel = 2'd0; din = '0;
    step();
    load = 1'b0; enc = 1'b0;
    total++;
    if ({err, rdy, busy} !== 3'b010) begin
      bad++;
      $display("FAIL load_prio: err/rdy/busy=%b want 010",
               {err, rdy, busy});
    end
  endtask

  task automatic test_abort();
    start(1'b0, 2'd0, 128'hF);
    for (int i = 0; i < 9; i++) step();
    abrt = 1'b1;
    step();
    abrt = 1'b0;
    total++;
    if ({rdy, busy, done} !== 3'b100 || dout !== PT) begin
      bad++;
      $display("FAIL abort_r10: rdy/busy/done=%b data=%h want 100 %h",
               {rdy, busy, done}, dout, PT);
    end
    start(1'b0, 2'd0, 128'hF);
    for (int i = 0; i < 63; i++) step();
    abrt = 1'b1;
    step();
    abrt = 1'b0;
    total++;
    if ({rdy, busy, done} !== 3'b100 || dout !== PT) begin
      bad++;
      $display("FAIL abort_last: rdy/busy/done=%b data=%h want 100 %h",
               {rdy, busy, done}, dout, PT);
    end
    abrt = 1'b1;
    step();
    abrt = 1'b0;
    total++;
    if ({rdy, err, done} !== 3'b100) begin
      bad++;
      $display("FAIL abort_idle: rdy/err/done=%b want 100",
               {rdy, err, done});
    end
  endtask

  task automatic test_rst_mid();
    start(1'b0, 2'd0, 128'h3);
    for (int i = 0; i < 19; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({rdy, busy, done} !== 3'b100 || dout !== '0) begin
      bad++;
      $display("FAIL rst_mid: rdy/busy/done=%b data=%h want 100 0",
               {rdy, busy, done}, dout);
    end
    start(1'b0, 2'd0, 128'h3);
    total++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_inval0: err=%b busy=%b want 1 0",
               err, busy);
    end
    start(1'b1, 2'd2, 128'h3);
    total++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_inval2: err=%b busy=%b want 1 0",
               err, busy);
    end
  endtask

  task automatic test_small();
    s_load = 1'b1; s_sel = 1'b0; s_din = 8'h00;
    step();
    s_load = 1'b0;
    s_enc = 1'b1; s_din = 8'h81;
    step();
    s_enc = 1'b0;
    total++;
    if (s_busy !== 1'b1 || s_done !== 1'b0) begin
      bad++;
      $display("FAIL small_busy: busy=%b done=%b want 1 0",
               s_busy, s_done);
    end
    step();
    total++;
    if (s_done !== 1'b1 || s_dout !== 8'h03
        || s_rdy !== 1'b1) begin
      bad++;
      $display("FAIL small_enc: done=%b rdy=%b data=%h want 1 1 03",
               s_done, s_rdy, s_dout);
    end
  endtask

  initial begin
    rst = 1'b1;
    load = 0; enc = 0; dec = 0; abrt = 0;
    sel = '0; din = '0;
    s_load = 0; s_enc = 0; s_dec = 0; s_abrt = 0;
    s_sel = '0; s_din = '0;
    test_reset();
    test_enc_basic();
    test_back_to_back();
    test_err();
    test_abort();
    test_rst_mid();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accel_model_param.md
ACCEL_MODEL_PARAM -- requirements
Module: accel_model_param

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning the data/key width in bits (>=8).
REQ-002 SHALL have parameter LATENCY, default 64, meaning the number of round cycles per operation (>=1).
REQ-003 SHALL have parameter NUM_KEYS, default 4, meaning the number of key slots (>=1); KS_W = max(1, clog2(NUM_KEYS)).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port load_key_i, input, 1 bit: writes data_i into slot key_sel_i.
REQ-007 SHALL have port key_sel_i, input, KS_W bits: key slot for a load or start.
REQ-008 SHALL have ports start_enc_i and start_dec_i, input, 1 bit each: start an encrypt or decrypt.
REQ-009 SHALL have port abort_i, input, 1 bit: cancels the operation in flight.
REQ-010 SHALL have port data_i, input, DATA_W bits: key or plaintext/ciphertext.
REQ-011 SHALL have port data_o, output, DATA_W bits: registered result.
REQ-012 SHALL have ports ready_o, done_o, busy_o, rf_en_o and err_o, output, 1 bit each.

Function
REQ-013 SHALL have an FSM with states IDLE and BUSY.
REQ-014 In IDLE, when exactly one of start_enc_i or start_dec_i is high, the selected slot is valid, and load_key_i is low, the block SHALL:
- capture data_i into the accumulator;
- latch the operation and the slot;
- set the counter to LATENCY;
- go to BUSY;
- drop ready_o.
REQ-015 SHALL perform one round on each BUSY cycle:
- enc: acc <= rotl(acc,1) XOR key;
- dec: acc <= rotr(acc XOR key,1).
REQ-016 On the BUSY cycle where the counter equals 1, the block SHALL:
- write the final round result to data_o;
- pulse done_o for exactly one cycle;
- raise ready_o;
- return to IDLE.
done_o is thus visible LATENCY edges after the start edge.
REQ-017 data_o SHALL hold its last result until the next completion; it does not change during BUSY.
REQ-018 busy_o and rf_en_o SHALL equal (state==BUSY); ready_o SHALL equal (state==IDLE).
REQ-019 In IDLE, load_key_i SHALL write data_i to slot key_sel_i and set that slot's valid bit; a load has priority over a start in the same cycle, and the start is dropped.
REQ-020 err_o SHALL pulse for one cycle, with no other state change, on any of these:
- start_enc_i and start_dec_i high together;
- a start to an invalid slot;
- load_key_i or a start while BUSY.
REQ-021 abort_i in BUSY SHALL return the block to IDLE on the next edge, with no done_o, data_o unchanged and ready_o high; abort_i in IDLE SHALL be ignored.
REQ-022 abort_i SHALL take priority over completion when it coincides with counter==1.
REQ-023 Key slots SHALL be read only at start; the latched slot index is used for all rounds.
REQ-024 The counter width SHALL be clog2(LATENCY+1); it never wraps below 1 while BUSY.

Reset
REQ-025 On rst high, the block SHALL enter IDLE and set:
- ready_o=1;
- done_o=0;
- err_o=0;
- data_o=0;
- accumulator=0;
- counter=0;
- all key-slot valid bits=0.
Key contents are don't-care.
REQ-026 rst asserted mid-operation SHALL abandon the operation with no done_o, taking effect on the same edge.

Structure
REQ-027 Package accel_model_pkg SHALL hold:
- the state enum (ST_IDLE, ST_BUSY);
- the operation enum (OP_ENC, OP_DEC);
- the default parameter constants.
REQ-028 The round function SHALL be a purely combinational sub-module, accel_model_round, parametrised by DATA_W, with inputs acc, key and op and output nxt.

Verification
REQ-029 Key 0 in slot 0, start_enc_i with data_i=128'h1 -> done_o after 64 edges, data_o=128'h1<<64, and ready_o/busy_o toggle correctly.
REQ-030 Key 128'hA5..A5 in slot 2: enc of 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, then dec of that result -> data_o equals the original plaintext.
REQ-031 start_enc_i and start_dec_i high together, and separately a start to unloaded slot 3 -> one err_o pulse each, state stays IDLE, ready_o=1.
REQ-032 abort_i at round 10, then at counter==1 -> no done_o, data_o keeps its previous value, ready_o=1 next cycle.
REQ-033 rst pulsed at round 20 -> IDLE, data_o=0, all slots invalid, and a subsequent start raises err_o.
REQ-034 DATA_W=8, LATENCY=1, NUM_KEYS=1, key 8'h00, enc of 8'h81 -> data_o=8'h03, done_o one edge after start.
